ysyx_24100006_axi_arbiter: RTL and testbench
============================================

# ysyx_24100006_axi_arbiter

Two-master, one-slave AXI4 arbiter in front of `ysyx_24100006_mem`. It shares the memory port between the IFU (read-only, burst capable) and the LSU (single-beat read/write). Exactly one transaction owns the slave at a time, from address handshake to final response. Non-owners see all ready/valid deasserted.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `ifu_araddr/arlen/arsize/arvalid`, in, 32/8/3/1: IFU read-address request.
- `ifu_arready`, out, 1: IFU read-address accept.
- `ifu_rdata/rresp/rlast/rvalid`, out, 32/2/1/1: IFU read data.
- `ifu_rready`, in, 1: IFU read-data accept.
- `lsu_ar*`, `lsu_r*`, same widths as IFU: LSU read channels.
- `lsu_awaddr/awlen/awsize/awvalid`, in, 32/8/3/1: LSU write address.
- `lsu_awready`, out, 1: LSU write-address accept.
- `lsu_wdata/wstrb/wlast/wvalid`, in, 32/4/1/1: LSU write data.
- `lsu_wready`, out, 1: LSU write-data accept.
- `lsu_bresp/bvalid`, out, 2/1: LSU write response.
- `lsu_bready`, in, 1: LSU write-response accept.
- `mem_*`, mirrored directions: full AXI master port to `ysyx_24100006_mem`, using the same signal set as above.

## Operation
- FSM states: `IDLE`, `IFU_RD`, `LSU_RD`, `LSU_WR`.
- `IDLE`: all channel routing is closed.
  - Request sources: `ifu_arvalid`, `lsu_arvalid`, and `lsu_awvalid && lsu_wvalid`.
  - Pick a winner and register the grant. The FSM moves to the winner's state on the next edge.
- LSU internal priority: write over read. A write needs `awvalid` and `wvalid` both high. A lone `awvalid` is not a request.
- IFU vs LSU, default build: fixed priority, LSU wins.
- `IFU_RD` / `LSU_RD`:
  - AR and R channels of the owner are wired combinationally to `mem_*`.
  - `mem_arvalid` is driven from the owner's `arvalid`.
  - Exit to `IDLE` on `mem_rvalid && mem_rready && mem_rlast`.
- `LSU_WR`:
  - AW, W and B channels are wired to the LSU.
  - Exit to `IDLE` on `mem_bvalid && mem_bready`.
- Outside the owning state:
  - `mem_*valid` outputs are driven 0.
  - Master-side `*ready` and `*valid` outputs are driven 0.
  - Data and address buses may carry don't-care values.
- The owner's pass-through payload is the same cycle as the slave (no pipeline register).
- A request that drops while waiting in `IDLE` is simply not granted. Masters must hold requests per the AXI rule.

## Timing
- Arbitration latency: 1 cycle.
  - Request seen in `IDLE` at edge N; grant state active after edge N.
  - `mem_arvalid`/`mem_awvalid` rise in cycle N+1.
- Turnaround: the cycle after the final handshake is `IDLE`. The next grant follows one edge later.
  - Minimum gap between back-to-back transactions: 1 idle cycle.
- A burst of `arlen`+1 beats holds the grant for all beats. The other master is stalled with `arready`=0.
- Reset values (asynchronous, on `reset`=0): state=`IDLE`, `rr_last`=IFU.
  - All `*valid`/`*ready` outputs to masters and slave are 0.
  - `rdata`, `rresp`, `bresp`, `rlast` are 0.
- Reset mid-transaction: the FSM returns to `IDLE` immediately. The slave is reset by the same net, so no transaction is completed.
- Simultaneous exit and new request on the same edge: the FSM goes to `IDLE` first. The new request is arbitrated on the following edge.

## Configuration
- `YSYX_24100006_ARB_RR_EN`
  - Defined: round-robin between IFU and LSU. A 1-bit `rr_last` register is updated at every grant. On contention the master not in `rr_last` wins.
  - Undefined: fixed LSU-over-IFU priority. `rr_last` is not built.
- LSU write-over-read priority is unchanged in both builds.

## Structure
- Shared package `ysyx_24100006_axi_pkg`:
  - State encoding `arb_state_t` (2-bit).
  - `AXI_RESP_OKAY`=2'b00 and `AXI_RESP_SLVERR`=2'b10.
  - Master ID constants `MID_IFU`=0 and `MID_LSU`=1.
- Sub-module `ysyx_24100006_arb_pick`: pure-combinational winner selection from the request vector and `rr_last`. The macro applies only there.
- The top contains the FSM and the channel muxes.

## Test plan
- IFU read only, `araddr`=0x8000_0000, `arlen`=3 → 4 beats routed to IFU, `rlast` on beat 4. LSU sees `rvalid`=0 throughout. `IDLE` is reached 1 cycle after the last beat.
- IFU and LSU reads in the same cycle (LSU addr 0x8000_0100), default build → LSU granted first and IFU after. With `_RR_EN` and `rr_last`=LSU, IFU is granted first.
- LSU write 0x8000_0010, data 0xDEADBEEF, `wstrb`=0xF, concurrent with LSU read request → write granted, `bvalid` to LSU. A read-back of 0x8000_0010 returns 0xDEADBEEF.
- LSU read arrives during an IFU 8-beat burst → `lsu_arready` stays 0 until the burst's `rlast` handshake. LSU is granted after the 1 idle cycle.
- `reset` driven low mid-burst at beat 2 → all valid/ready outputs are 0 asynchronously. After release, the state is `IDLE` and a fresh IFU read completes normally.
- Back-to-back: 16 alternating IFU/LSU single-beat reads under `_RR_EN` → grants strictly alternate, every data beat reaches the correct master, no lost handshakes.

Source files
------------

// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared types and constants for the two-master AXI arbiter.
package ysyx_24100006_axi_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;
endpackage

// File: rtl/ysyx_24100006_arb_pick.sv
// Combinational winner selection. YSYX_24100006_ARB_RR_EN selects round-robin
// between IFU and LSU; otherwise the LSU always beats the IFU.
module ysyx_24100006_arb_pick
  import ysyx_24100006_axi_pkg::*;
(
  input  logic       ifu_req_i,
  input  logic       lsu_rd_req_i,
  input  logic       lsu_wr_req_i,
`ifdef YSYX_24100006_ARB_RR_EN
  input  logic       rr_last_i,
`endif
  output arb_state_t grant_o
);
  logic lsu_req, lsu_win;

  assign lsu_req = lsu_rd_req_i | lsu_wr_req_i;
`ifdef YSYX_24100006_ARB_RR_EN
  // On contention the master that did not win last time goes first.
  assign lsu_win = lsu_req & (~ifu_req_i | (rr_last_i == MID_IFU));
`else
  assign lsu_win = lsu_req;
`endif

  always_comb begin
    grant_o = IDLE;
    if (lsu_win)        grant_o = lsu_wr_req_i ? LSU_WR : LSU_RD;
    else if (ifu_req_i) grant_o = IFU_RD;
  end
endmodule

// File: rtl/ysyx_24100006_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI arbiter. Whole-transaction
// ownership; routing is combinational. Optional YSYX_24100006_ARB_RR_EN: round-robin.
module ysyx_24100006_axi_arbiter
  import ysyx_24100006_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rlast,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rlast,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wlast,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic [7:0]          mem_arlen,
  output logic [2:0]          mem_arsize,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rlast,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic [7:0]          mem_awlen,
  output logic [2:0]          mem_awsize,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_wlast,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid,
  output logic                mem_bready
);
  arb_state_t state_q, grant;
  logic       own_ifu, own_lrd, own_lwr;

`ifdef YSYX_24100006_ARB_RR_EN
  logic rr_last_q;
`endif

  ysyx_24100006_arb_pick u_pick (
    .ifu_req_i    (ifu_arvalid),
    .lsu_rd_req_i (lsu_arvalid),
    .lsu_wr_req_i (lsu_awvalid & lsu_wvalid),
`ifdef YSYX_24100006_ARB_RR_EN
    .rr_last_i    (rr_last_q),
`endif
    .grant_o      (grant)
  );

  // The final handshake returns to IDLE; the next winner is picked one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
`ifdef YSYX_24100006_ARB_RR_EN
      rr_last_q <= MID_IFU;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= grant;
`ifdef YSYX_24100006_ARB_RR_EN
          if (grant != IDLE) rr_last_q <= (grant == IFU_RD) ? MID_IFU : MID_LSU;
`endif
        end
        IFU_RD, LSU_RD: if (mem_rvalid && mem_rready && mem_rlast) state_q <= IDLE;
        LSU_WR:         if (mem_bvalid && mem_bready) state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

  assign own_ifu = (state_q == IFU_RD);
  assign own_lrd = (state_q == LSU_RD);
  assign own_lwr = (state_q == LSU_WR);

  assign mem_araddr  = own_lrd ? lsu_araddr : ifu_araddr;
  assign mem_arlen   = own_lrd ? lsu_arlen  : ifu_arlen;
  assign mem_arsize  = own_lrd ? lsu_arsize : ifu_arsize;
  assign mem_arvalid = (own_ifu & ifu_arvalid) | (own_lrd & lsu_arvalid);
  assign mem_rready  = (own_ifu & ifu_rready)  | (own_lrd & lsu_rready);

  assign ifu_arready = own_ifu & mem_arready;
  assign ifu_rvalid  = own_ifu & mem_rvalid;
  assign ifu_rdata   = own_ifu ? mem_rdata : '0;
  assign ifu_rresp   = own_ifu ? mem_rresp : AXI_RESP_OKAY;
  assign ifu_rlast   = own_ifu & mem_rlast;

  assign lsu_arready = own_lrd & mem_arready;
  assign lsu_rvalid  = own_lrd & mem_rvalid;
  assign lsu_rdata   = own_lrd ? mem_rdata : '0;
  assign lsu_rresp   = own_lrd ? mem_rresp : AXI_RESP_OKAY;
  assign lsu_rlast   = own_lrd & mem_rlast;

  assign mem_awaddr  = lsu_awaddr;
  assign mem_awlen   = lsu_awlen;
  assign mem_awsize  = lsu_awsize;
  assign mem_wdata   = lsu_wdata;
  assign mem_wstrb   = lsu_wstrb;
  assign mem_wlast   = lsu_wlast;
  assign mem_awvalid = own_lwr & lsu_awvalid;
  assign mem_wvalid  = own_lwr & lsu_wvalid;
  assign mem_bready  = own_lwr & lsu_bready;

  assign lsu_awready = own_lwr & mem_awready;
  assign lsu_wready  = own_lwr & mem_wready;
  assign lsu_bvalid  = own_lwr & mem_bvalid;
  assign lsu_bresp   = own_lwr ? mem_bresp : AXI_RESP_OKAY;
endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed bench: AXI slave memory model, master tasks, and an ownership model
// checked against the DUT every cycle.
module tb_ysyx_24100006_axi_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
  logic [7:0]  ifu_arlen = '0, lsu_arlen = '0, lsu_awlen = '0;
  logic [2:0]  ifu_arsize = '0, lsu_arsize = '0, lsu_awsize = '0;
  logic        ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
  logic        lsu_awvalid = 0, lsu_wvalid = 0, lsu_wlast = 0, lsu_bready = 0;
  logic [3:0]  lsu_wstrb = '0;
  logic        ifu_arready, ifu_rlast, ifu_rvalid, lsu_arready, lsu_rlast, lsu_rvalid;
  logic        lsu_awready, lsu_wready, lsu_bvalid;
  logic [31:0] ifu_rdata, lsu_rdata;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
  logic [31:0] mem_araddr, mem_awaddr, mem_wdata;
  logic [7:0]  mem_arlen, mem_awlen;
  logic [2:0]  mem_arsize, mem_awsize;
  logic [3:0]  mem_wstrb;
  logic        mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_wlast, mem_bready;
  logic        mem_arready = 0, mem_rlast = 0, mem_rvalid = 0, mem_awready = 0;
  logic        mem_wready = 0, mem_bvalid = 0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  mem_rresp = '0, mem_bresp = '0;

  ysyx_24100006_axi_arbiter dut (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
    .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata),
    .lsu_rresp(lsu_rresp), .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
    .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata),
    .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_rdata(mem_rdata),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- slave memory model ----------------
  logic [31:0] smem [logic [31:0]];
  function automatic logic [31:0] rdmem(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : (a ^ 32'h1234_5678);
  endfunction

  logic        s_rst, s_ar, s_r, s_w, s_b, rd_act = 0, wr_act = 0;
  logic [31:0] s_ra, s_aa, s_wd, s_old;
  logic [7:0]  s_rl, s_al;
  logic [3:0]  s_ws;
  initial begin
    forever begin
      @(negedge clk);
      s_rst = !reset;
      s_ar = mem_arvalid && mem_arready;  s_r = mem_rvalid && mem_rready;
      s_w  = mem_awvalid && mem_awready && mem_wvalid && mem_wready;
      s_b  = mem_bvalid && mem_bready;
      s_aa = s_ar ? mem_araddr : mem_awaddr;  s_al = mem_arlen;
      s_wd = mem_wdata;  s_ws = mem_wstrb;
      @(posedge clk); #1;
      if (s_rst) begin
        rd_act = 0; wr_act = 0; mem_rvalid = 0; mem_rlast = 0; mem_rdata = '0; mem_bvalid = 0;
      end else begin
        if (s_ar) begin
          rd_act = 1; s_ra = s_aa; s_rl = s_al;
          mem_rvalid = 1; mem_rdata = rdmem(s_ra); mem_rlast = (s_rl == 0);
        end else if (s_r) begin
          if (mem_rlast) begin rd_act = 0; mem_rvalid = 0; mem_rlast = 0; end
          else begin
            s_ra += 4; s_rl -= 1;
            mem_rdata = rdmem(s_ra); mem_rlast = (s_rl == 0);
          end
        end
        if (s_w) begin
          s_old = rdmem(s_aa);
          for (int b = 0; b < 4; b++) if (s_ws[b]) s_old[b*8 +: 8] = s_wd[b*8 +: 8];
          smem[s_aa] = s_old;
          wr_act = 1; mem_bvalid = 1; mem_bresp = 2'b00;
        end else if (s_b) begin
          wr_act = 0; mem_bvalid = 0;
        end
      end
      mem_arready = !rd_act && !wr_act;
      mem_awready = !rd_act && !wr_act;
      mem_wready  = !rd_act && !wr_act;
    end
  end

  // ---------------- ownership model and per-cycle compare ----------------
  // own: 0 none, 1 IFU read, 2 LSU read, 3 LSU write. rr: 0 IFU won last, 1 LSU.
  int   own = 0, nxt = 0, cyc = 0, ifu_last_cyc = 0, lsu_ar_cyc = 0;
  bit   rr = 0, lsu_first;
  int   hs_log[$];
  logic [11:0] ctl_a, ctl_e;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin own = 0; rr = 0; end
      ctl_a = {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready, ifu_arready,
               ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid};
      ctl_e = {(own == 1) ? ifu_arvalid : (own == 2) ? lsu_arvalid : 1'b0,
               (own == 1) ? ifu_rready  : (own == 2) ? lsu_rready  : 1'b0,
               own == 3 && lsu_awvalid, own == 3 && lsu_wvalid, own == 3 && lsu_bready,
               own == 1 && mem_arready, own == 1 && mem_rvalid,
               own == 2 && mem_arready, own == 2 && mem_rvalid,
               own == 3 && mem_awready, own == 3 && mem_wready, own == 3 && mem_bvalid};
      chk("ctl", 64'(ctl_a), 64'(ctl_e));
      if (own == 1 && mem_arvalid) chk("ifu_ar", 64'({mem_araddr, mem_arlen, mem_arsize}),
                                       64'({ifu_araddr, ifu_arlen, ifu_arsize}));
      if (own == 2 && mem_arvalid) chk("lsu_ar", 64'({mem_araddr, mem_arlen, mem_arsize}),
                                       64'({lsu_araddr, lsu_arlen, lsu_arsize}));
      if (own == 1 && mem_rvalid) chk("ifu_r", 64'({ifu_rdata, ifu_rlast, ifu_rresp}),
                                      64'({mem_rdata, mem_rlast, mem_rresp}));
      if (own == 2 && mem_rvalid) chk("lsu_r", 64'({lsu_rdata, lsu_rlast, lsu_rresp}),
                                      64'({mem_rdata, mem_rlast, mem_rresp}));
      if (own == 3 && mem_awvalid) chk("lsu_w", {mem_awaddr, mem_wdata}, {lsu_awaddr, lsu_wdata});
      // observed handshakes, used for order checks
      if (ifu_arvalid && ifu_arready) hs_log.push_back(1);
      if (lsu_arvalid && lsu_arready) begin hs_log.push_back(2); lsu_ar_cyc = cyc; end
      if (lsu_awvalid && lsu_awready) hs_log.push_back(3);
      if (ifu_rvalid && ifu_rready && ifu_rlast) ifu_last_cyc = cyc;
      // next owner from the arbitration rules
      nxt = own;
      if (!reset) nxt = 0;
      else if (own == 0) begin
`ifdef YSYX_24100006_ARB_RR_EN
        lsu_first = (rr == 0);
`else
        lsu_first = 1;
`endif
        if ((lsu_awvalid && lsu_wvalid || lsu_arvalid) && (!ifu_arvalid || lsu_first))
          nxt = (lsu_awvalid && lsu_wvalid) ? 3 : 2;
        else if (ifu_arvalid) nxt = 1;
        if (nxt == 1) rr = 0; else if (nxt != 0) rr = 1;
      end else if (own != 3 && mem_rvalid && mem_rready && mem_rlast) nxt = 0;
      else if (own == 3 && mem_bvalid && mem_bready) nxt = 0;
      @(posedge clk);
      own = nxt;
    end
  end

  // ---------------- master tasks (called at posedge+1) ----------------
  logic [31:0] ifu_q[$], lsu_q[$];
  task automatic rd(input bit m, input logic [31:0] a, input logic [7:0] len, input int abort_at);
    int n = 0, beats = 0; bit ok; logic [31:0] d; logic l;
    if (!m) begin ifu_araddr = a; ifu_arlen = len; ifu_arsize = 3'd2; ifu_arvalid = 1; end
    else    begin lsu_araddr = a; lsu_arlen = len; lsu_arsize = 3'd2; lsu_arvalid = 1; end
    do begin
      @(negedge clk); ok = m ? lsu_arready : ifu_arready;
      @(posedge clk); #1;
      if (++n > 300) begin n_chk++; $display("FAIL ar_timeout m=%0d got none expected handshake", m); return; end
    end while (!ok);
    if (!m) begin ifu_arvalid = 0; ifu_rready = 1; end else begin lsu_arvalid = 0; lsu_rready = 1; end
    n = 0;
    forever begin
      @(negedge clk);
      ok = m ? lsu_rvalid : ifu_rvalid; d = m ? lsu_rdata : ifu_rdata; l = m ? lsu_rlast : ifu_rlast;
      @(posedge clk); #1;
      if (ok) begin
        if (m) lsu_q.push_back(d); else ifu_q.push_back(d);
        beats++;
        if (l || beats == abort_at) break;
      end
      if (++n > 300) begin n_chk++; $display("FAIL r_timeout m=%0d got none expected beat", m); break; end
    end
    if (!m) ifu_rready = 0; else lsu_rready = 0;
  endtask

  logic [1:0] got_bresp;
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0; bit ok;
    lsu_awaddr = a; lsu_awlen = 0; lsu_awsize = 3'd2; lsu_awvalid = 1;
    lsu_wdata = d; lsu_wstrb = s; lsu_wlast = 1; lsu_wvalid = 1;
    do begin
      @(negedge clk); ok = lsu_awready && lsu_wready;
      @(posedge clk); #1;
      if (++n > 300) begin n_chk++; $display("FAIL aw_timeout got none expected handshake"); return; end
    end while (!ok);
    lsu_awvalid = 0; lsu_wvalid = 0; lsu_bready = 1;
    n = 0;
    do begin
      @(negedge clk); ok = lsu_bvalid; got_bresp = lsu_bresp;
      @(posedge clk); #1;
      if (++n > 300) begin n_chk++; $display("FAIL b_timeout got none expected bvalid"); break; end
    end while (!ok);
    lsu_bready = 0;
  endtask

  task automatic clr();
    hs_log.delete(); ifu_q.delete(); lsu_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  int bad;
  initial begin
    @(posedge clk); #1;
    chk("reset_ctl", 64'({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_bvalid,
                          mem_arvalid, mem_awvalid, mem_wvalid, mem_rready, mem_bready}), 64'd0);
    chk("reset_data", 64'({ifu_rdata, ifu_rlast, ifu_rresp, lsu_bresp}), 64'd0);
    repeat (2) @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;

    // IFU 4-beat burst
    clr(); rd(0, 32'h8000_0000, 8'd3, -1);
    chk("ifu_beats", 64'(ifu_q.size()), 64'd4);
    if (ifu_q.size() == 4) begin
      chk("ifu_b0", 64'(ifu_q[0]), 64'h9234_5678);
      chk("ifu_b1", 64'(ifu_q[1]), 64'h9234_567C);
      chk("ifu_b2", 64'(ifu_q[2]), 64'h9234_5670);
      chk("ifu_b3", 64'(ifu_q[3]), 64'h9234_5674);
    end
    chk("lsu_nodata", 64'(lsu_q.size()), 64'd0);

    // LSU alone, then simultaneous IFU/LSU reads
    clr(); rd(1, 32'h8000_0100, 8'd0, -1);
    chk("lsu_single", 64'(lsu_q.size() > 0 ? lsu_q[0] : 32'h0), 64'h9234_5778);
    clr();
    fork
      rd(0, 32'h8000_0200, 8'd0, -1);
      rd(1, 32'h8000_0100, 8'd0, -1);
    join
    chk("contend_n", 64'(hs_log.size()), 64'd2);
`ifdef YSYX_24100006_ARB_RR_EN
    if (hs_log.size() == 2) chk("contend_order", 64'({hs_log[0], hs_log[1]}), {32'd1, 32'd2});
`else
    if (hs_log.size() == 2) chk("contend_order", 64'({hs_log[0], hs_log[1]}), {32'd2, 32'd1});
`endif
    chk("contend_ifu", 64'(ifu_q.size() > 0 ? ifu_q[0] : 32'h0), 64'h9234_5478);

    // LSU write concurrent with LSU read of the same address
    clr();
    fork
      wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
      rd(1, 32'h8000_0010, 8'd0, -1);
    join
    if (hs_log.size() == 2) chk("wr_first", 64'({hs_log[0], hs_log[1]}), {32'd3, 32'd2});
    else chk("wr_first_n", 64'(hs_log.size()), 64'd2);
    chk("bresp", 64'(got_bresp), 64'd0);
    chk("readback", 64'(lsu_q.size() > 0 ? lsu_q[0] : 32'h0), 64'hDEAD_BEEF);

    // LSU read arriving during an 8-beat IFU burst
    clr();
    fork
      rd(0, 32'h8000_1000, 8'd7, -1);
      begin repeat (3) @(posedge clk); #1; rd(1, 32'h8000_2000, 8'd0, -1); end
    join
    chk("burst_beats", 64'(ifu_q.size()), 64'd8);
    if (ifu_q.size() == 8) chk("burst_last", 64'(ifu_q[7]), 64'h9234_4664);
    chk("lsu_after_burst", 64'(lsu_ar_cyc - ifu_last_cyc), 64'd2);
    if (hs_log.size() == 2) chk("burst_order", 64'({hs_log[0], hs_log[1]}), {32'd1, 32'd2});

    // Reset in the middle of a burst
    clr(); rd(0, 32'h8000_3000, 8'd7, 2);
    reset = 0; #1;
    chk("async_rst_ctl", 64'({ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready,
                              lsu_wready, lsu_bvalid, mem_arvalid, mem_rready, mem_awvalid,
                              mem_wvalid, mem_bready}), 64'd0);
    chk("async_rst_data", 64'({ifu_rdata, ifu_rlast, lsu_rlast}), 64'd0);
    repeat (2) @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    clr(); rd(0, 32'h8000_0040, 8'd1, -1);
    chk("post_rst_n", 64'(ifu_q.size()), 64'd2);
    if (ifu_q.size() == 2) chk("post_rst_d", {ifu_q[0], ifu_q[1]}, {32'h9234_5638, 32'h9234_563C});

    // 16 back-to-back single-beat reads from both masters
    clr();
    fork
      for (int i = 0; i < 8; i++) rd(0, 32'h8000_4000 + 32'(i * 4), 8'd0, -1);
      for (int j = 0; j < 8; j++) rd(1, 32'h8000_5000 + 32'(j * 4), 8'd0, -1);
    join
    chk("b2b_n", 64'(hs_log.size()), 64'd16);
    bad = 0;
`ifdef YSYX_24100006_ARB_RR_EN
    for (int k = 1; k < hs_log.size(); k++) if (hs_log[k] == hs_log[k-1]) bad++;
`else
    for (int k = 0; k < 8 && k < hs_log.size(); k++) if (hs_log[k] != 2) bad++;
`endif
    chk("b2b_order", 64'(bad), 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk("b2b_ifu", 64'(k < ifu_q.size() ? ifu_q[k] : 32'h0), 64'((32'h8000_4000 + 32'(k * 4)) ^ 32'h1234_5678));
      chk("b2b_lsu", 64'(k < lsu_q.size() ? lsu_q[k] : 32'h0), 64'((32'h8000_5000 + 32'(k * 4)) ^ 32'h1234_5678));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
